// File: rtl/router_pkg.sv
// Shared router types and constants: port count, flit width, output-port FSM states and the
// flit record carried on a link.
package router_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned FLIT_W    = 32;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } port_state_t;

  typedef struct packed {
    logic              tail;
    logic [FLIT_W-1:0] payload;
  } flit_t;

endpackage

// File: rtl/router_output_port_if.sv
// Handshake bundle between the router input buffers/arbiter, one output port and its link.
// The slave modport is the output-port stage; the master modport is its surroundings.
interface router_output_port_if #(
  parameter int unsigned NUM_IN = router_pkg::NUM_PORTS,
  parameter int unsigned FLIT_W = router_pkg::FLIT_W
);

  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*FLIT_W-1:0] in_flit;
  logic [NUM_IN-1:0]        in_tail;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN-1:0]        arb_requests;
  logic [NUM_IN-1:0]        arb_select;
  logic                     arb_next;
  logic                     credit_in;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_tail;
  logic                     err;

  modport slave (
    input  in_valid,
    input  in_flit,
    input  in_tail,
    input  arb_select,
    input  credit_in,
    output in_ready,
    output arb_requests,
    output arb_next,
    output out_valid,
    output out_flit,
    output out_tail,
    output err
  );

  modport master (
    output in_valid,
    output in_flit,
    output in_tail,
    output arb_select,
    output credit_in,
    input  in_ready,
    input  arb_requests,
    input  arb_next,
    input  out_valid,
    input  out_flit,
    input  out_tail,
    input  err
  );

endinterface

// File: rtl/router_credit_counter.sv
// Downstream credit tracker for one output link: counts free slots in the next router's buffer,
// saturating at CREDITS and flagging a credit returned while already full.
module router_credit_counter #(
  parameter int unsigned CREDITS = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic dec,
  input  logic inc,
  output logic can_send,
  output logic overflow
);

  localparam int unsigned CntW = $clog2(CREDITS + 1);
  localparam logic [CntW-1:0] Full = CntW'(CREDITS);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A send and a returned credit in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end else if (inc && !dec && (cnt_q != Full)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= Full;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign can_send = (cnt_q != '0);
  assign overflow = inc && (cnt_q == Full);

endmodule

// File: rtl/router_output_port.sv
// One output port of the mesh router: locks the arbiter's winner for a wormhole packet, muxes its
// flits onto a registered link and meters them with credits. ROUTER_OUTPUT_PORT_ERR_CHECK_EN adds err.
module router_output_port #(
  parameter int unsigned NUM_IN  = router_pkg::NUM_PORTS,
  parameter int unsigned FLIT_W  = router_pkg::FLIT_W,
  parameter int unsigned CREDITS = 4
) (
  input logic                 CLK,
  input logic                 RST_N,
  router_output_port_if.slave port
);

  import router_pkg::*;

  port_state_t       state_q, state_d;
  logic [NUM_IN-1:0] owner_q, owner_d;
  logic [NUM_IN-1:0] in_ready;
  logic [NUM_IN-1:0] arb_requests;
  logic              arb_next;
  logic              send;
  logic              can_send;
  logic              overflow;

  logic [FLIT_W-1:0] sel_flit;
  logic              sel_tail;

  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              out_tail_q, out_tail_d;

  router_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit_counter (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .dec      (send),
    .inc      (port.credit_in),
    .can_send (can_send),
    .overflow (overflow)
  );

  // Nothing is dequeued while reset is held, so no flit is lost in the reset cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    in_ready     = '0;
    arb_requests = '0;
    arb_next     = 1'b0;
    send         = 1'b0;
    if (RST_N) begin
      unique case (state_q)
        IDLE: begin
          if (can_send) begin
            arb_requests = port.in_valid;
          end
          if ((port.arb_select != '0) && can_send) begin
            send     = 1'b1;
            owner_d  = port.arb_select;
            in_ready = port.arb_select;
            if ((port.arb_select & port.in_tail) != '0) begin
              arb_next = 1'b1;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (can_send && ((port.in_valid & owner_q) != '0)) begin
            send     = 1'b1;
            in_ready = owner_q;
            if ((owner_q & port.in_tail) != '0) begin
              arb_next = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sel_flit = '0;
    sel_tail = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_ready[i]) begin
        sel_flit = sel_flit | port.in_flit[i*FLIT_W +: FLIT_W];
        sel_tail = sel_tail | port.in_tail[i];
      end
    end
  end

  always_comb begin
    out_valid_d = send;
    out_flit_d  = send ? sel_flit : out_flit_q;
    out_tail_d  = send ? sel_tail : out_tail_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_tail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_tail_q  <= out_tail_d;
    end
  end

  assign port.in_ready     = in_ready;
  assign port.arb_requests = arb_requests;
  assign port.arb_next     = arb_next;
  assign port.out_valid    = out_valid_q;
  assign port.out_flit     = out_flit_q;
  assign port.out_tail     = out_tail_q;

`ifdef ROUTER_OUTPUT_PORT_ERR_CHECK_EN
  logic err_q, err_d;

  // Sticky: full-counter credit return, multi-hot grant, or a grant nobody requested.
  always_comb begin
    err_d = err_q;
    if (overflow) begin
      err_d = 1'b1;
    end
    if ((port.arb_select & (port.arb_select - NUM_IN'(1))) != '0) begin
      err_d = 1'b1;
    end
    if ((port.arb_select != '0) && (arb_requests == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign port.err = err_q;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign port.err        = 1'b0;
`endif

endmodule

// File: tb/tb_router_output_port.sv
// Bench for router_output_port: directed scenarios for locking, credit stall, reset and err,
// then randomized traffic checked against a packet/credit-level model of the port.
module tb_router_output_port;
  import router_pkg::*;

  localparam int unsigned N = 5;
  localparam int unsigned W = 32;
  localparam int unsigned C = 4;
`ifdef ROUTER_OUTPUT_PORT_ERR_CHECK_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  router_output_port_if #(.NUM_IN(N), .FLIT_W(W)) bus ();

  router_output_port #(
    .NUM_IN  (N),
    .FLIT_W  (W),
    .CREDITS (C)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .port  (bus)
  );

  task automatic idle_inputs();
    bus.in_valid   = '0;
    bus.in_flit    = '0;
    bus.in_tail    = '0;
    bus.arb_select = '0;
    bus.credit_in  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_flit(input int i, input logic [W-1:0] f, input logic t);
    bus.in_valid[i]        = 1'b1;
    bus.in_flit[i*W +: W]  = f;
    bus.in_tail[i]         = t;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_flit !== '0) begin bad++; $display("FAIL rst_out_flit got=%h exp=0", bus.out_flit); end
    total++; if (bus.out_tail !== 1'b0) begin bad++; $display("FAIL rst_out_tail got=%b exp=0", bus.out_tail); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    #1;
    total++; if (bus.arb_requests !== 5'b00000) begin bad++; $display("FAIL rst_req_none got=%b exp=00000", bus.arb_requests); end
    bus.in_valid = 5'b11111;
    #1;
    total++; if (bus.arb_requests !== 5'b11111) begin bad++; $display("FAIL rst_req_all got=%b exp=11111", bus.arb_requests); end
    idle_inputs();
  endtask

  task automatic test_single_flit();
    do_reset();
    set_flit(2, 32'hA5A5_0002, 1'b1);
    bus.arb_select = 5'b00100;
    #1;
    total++; if (bus.in_ready !== 5'b00100) begin bad++; $display("FAIL single_ready got=%b exp=00100", bus.in_ready); end
    total++; if (bus.arb_next !== 1'b1) begin bad++; $display("FAIL single_next got=%b exp=1", bus.arb_next); end
    @(negedge clk);
    idle_inputs();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_flit !== 32'hA5A5_0002) begin bad++; $display("FAIL single_out_flit got=%h exp=a5a50002", bus.out_flit); end
    total++; if (bus.out_tail !== 1'b1) begin bad++; $display("FAIL single_out_tail got=%b exp=1", bus.out_tail); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_flit !== 32'hA5A5_0002) begin bad++; $display("FAIL single_flit_hold got=%h exp=a5a50002", bus.out_flit); end
    // Three more single-flit packets back to back use up the remaining three credits.
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      idle_inputs();
      set_flit(0, 32'h100 + k, 1'b1);
      bus.arb_select = 5'b00001;
      #1;
      total++; if (bus.in_ready !== 5'b00001) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=00001", k, bus.in_ready); end
    end
    @(negedge clk);
    total++; if (bus.out_flit !== 32'h102) begin bad++; $display("FAIL b2b_last_flit got=%h exp=102", bus.out_flit); end
    idle_inputs();
    set_flit(0, 32'h103, 1'b1);
    #1;
    total++; if (bus.arb_requests !== 5'b00000) begin bad++; $display("FAIL credits_exhausted got=%b exp=00000", bus.arb_requests); end
    bus.credit_in = 1'b1;
    @(negedge clk);
    bus.credit_in = 1'b0;
    #1;
    total++; if (bus.arb_requests !== 5'b00001) begin bad++; $display("FAIL credit_return_req got=%b exp=00001", bus.arb_requests); end
    idle_inputs();
  endtask

  task automatic test_locked();
    do_reset();
    set_flit(1, 32'h1000, 1'b0);
    set_flit(3, 32'h3333, 1'b1);
    #1;
    total++; if (bus.arb_requests !== 5'b01010) begin bad++; $display("FAIL lock_req got=%b exp=01010", bus.arb_requests); end
    bus.arb_select = 5'b00010;
    #1;
    total++; if (bus.in_ready !== 5'b00010) begin bad++; $display("FAIL lock_head_ready got=%b exp=00010", bus.in_ready); end
    total++; if (bus.arb_next !== 1'b0) begin bad++; $display("FAIL lock_head_next got=%b exp=0", bus.arb_next); end
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      bus.arb_select = '0;
      bus.credit_in  = 1'b1;
      total++; if (bus.out_flit !== 32'h1000 + k - 1) begin bad++; $display("FAIL lock_out_flit[%0d] got=%h exp=%h", k, bus.out_flit, 32'h1000 + k - 1); end
      set_flit(1, 32'h1000 + k, k == 2);
      #1;
      total++; if (bus.arb_requests !== 5'b00000) begin bad++; $display("FAIL lock_req_zero[%0d] got=%b exp=00000", k, bus.arb_requests); end
      total++; if (bus.in_ready !== 5'b00010) begin bad++; $display("FAIL lock_body_ready[%0d] got=%b exp=00010", k, bus.in_ready); end
      total++; if (bus.arb_next !== (k == 2)) begin bad++; $display("FAIL lock_body_next[%0d] got=%b exp=%b", k, bus.arb_next, k == 2); end
    end
    @(negedge clk);
    bus.credit_in = 1'b0;
    total++; if (bus.out_tail !== 1'b1) begin bad++; $display("FAIL lock_tail_out got=%b exp=1", bus.out_tail); end
    bus.in_valid[1] = 1'b0;
    #1;
    total++; if (bus.arb_requests !== 5'b01000) begin bad++; $display("FAIL lock_next_req got=%b exp=01000", bus.arb_requests); end
    bus.arb_select = 5'b01000;
    #1;
    total++; if (bus.in_ready !== 5'b01000) begin bad++; $display("FAIL lock_next_ready got=%b exp=01000", bus.in_ready); end
    @(negedge clk);
    idle_inputs();
    total++; if (bus.out_flit !== 32'h3333) begin bad++; $display("FAIL lock_next_flit got=%h exp=3333", bus.out_flit); end
  endtask

  task automatic test_credit_stall();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      set_flit(0, 32'h2000 + k, 1'b0);
      bus.arb_select = (k == 0) ? 5'b00001 : 5'b00000;
      #1;
      total++; if (bus.in_ready !== 5'b00001) begin bad++; $display("FAIL stall_pre_ready[%0d] got=%b exp=00001", k, bus.in_ready); end
    end
    @(negedge clk);
    bus.arb_select = '0;
    total++; if (bus.out_flit !== 32'h2003) begin bad++; $display("FAIL stall_flit4 got=%h exp=2003", bus.out_flit); end
    set_flit(0, 32'h2004, 1'b0);
    #1;
    total++; if (bus.in_ready !== 5'b00000) begin bad++; $display("FAIL stall_ready got=%b exp=00000", bus.in_ready); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_out_valid got=%b exp=0", bus.out_valid); end
    bus.credit_in = 1'b1;
    #1;
    total++; if (bus.in_ready !== 5'b00000) begin bad++; $display("FAIL stall_credit_cycle got=%b exp=00000", bus.in_ready); end
    @(negedge clk);
    bus.credit_in = 1'b0;
    #1;
    total++; if (bus.in_ready !== 5'b00001) begin bad++; $display("FAIL resume_ready got=%b exp=00001", bus.in_ready); end
    @(negedge clk);
    total++; if (bus.out_flit !== 32'h2004) begin bad++; $display("FAIL resume_flit got=%h exp=2004", bus.out_flit); end
    set_flit(0, 32'h2005, 1'b1);
    #1;
    total++; if (bus.in_ready !== 5'b00000) begin bad++; $display("FAIL stall2_ready got=%b exp=00000", bus.in_ready); end
    bus.credit_in = 1'b1;
    @(negedge clk);
    bus.credit_in = 1'b0;
    #1;
    total++; if (bus.arb_next !== 1'b1) begin bad++; $display("FAIL stall_tail_next got=%b exp=1", bus.arb_next); end
    @(negedge clk);
    idle_inputs();
    total++; if (bus.out_flit !== 32'h2005 || bus.out_tail !== 1'b1) begin bad++; $display("FAIL stall_tail_out got=%h/%b exp=2005/1", bus.out_flit, bus.out_tail); end
  endtask

  task automatic test_same_cycle_credit();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      idle_inputs();
      set_flit(k, 32'h50 + k, 1'b1);
      bus.arb_select = 5'b00001 << k;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      set_flit(4, 32'h3000 + k, k == 3);
      bus.arb_select = (k == 0) ? 5'b10000 : 5'b00000;
      bus.credit_in  = 1'b1;
      #1;
      total++; if (bus.in_ready !== 5'b10000) begin bad++; $display("FAIL samecyc_ready[%0d] got=%b exp=10000", k, bus.in_ready); end
    end
    @(negedge clk);
    idle_inputs();
    total++; if (bus.out_flit !== 32'h3003) begin bad++; $display("FAIL samecyc_flit got=%h exp=3003", bus.out_flit); end
    set_flit(0, 32'h3100, 1'b1);
    #1;
    total++; if (bus.arb_requests !== 5'b00001) begin bad++; $display("FAIL samecyc_one_left got=%b exp=00001", bus.arb_requests); end
    bus.arb_select = 5'b00001;
    @(negedge clk);
    idle_inputs();
    set_flit(0, 32'h3101, 1'b1);
    #1;
    total++; if (bus.arb_requests !== 5'b00000) begin bad++; $display("FAIL samecyc_none_left got=%b exp=00000", bus.arb_requests); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_flit(4, 32'h4000, 1'b0);
    bus.arb_select = 5'b10000;
    @(negedge clk);
    bus.arb_select = '0;
    set_flit(4, 32'h4001, 1'b0);
    @(negedge clk);
    set_flit(4, 32'h4002, 1'b0);
    rst_n = 1'b0;
    #1;
    total++; if (bus.in_ready !== 5'b00000) begin bad++; $display("FAIL rstmid_ready got=%b exp=00000", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
    #1;
    total++; if (bus.arb_requests !== 5'b10000) begin bad++; $display("FAIL rstmid_idle_req got=%b exp=10000", bus.arb_requests); end
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      idle_inputs();
      set_flit(0, 32'h4100 + k, 1'b1);
      bus.arb_select = 5'b00001;
      #1;
      total++; if (bus.in_ready !== 5'b00001) begin bad++; $display("FAIL rstmid_new_ready[%0d] got=%b exp=00001", k, bus.in_ready); end
    end
    @(negedge clk);
    idle_inputs();
    total++; if (bus.out_flit !== 32'h4103) begin bad++; $display("FAIL rstmid_new_flit got=%h exp=4103", bus.out_flit); end
    set_flit(0, 32'h4104, 1'b1);
    #1;
    total++; if (bus.arb_requests !== 5'b00000) begin bad++; $display("FAIL rstmid_credits4 got=%b exp=00000", bus.arb_requests); end
    idle_inputs();
  endtask

  task automatic test_err();
    do_reset();
    set_flit(2, 32'h5, 1'b1);
    set_flit(3, 32'h6, 1'b1);
    bus.arb_select = 5'b01100;
    @(negedge clk);
    idle_inputs();
    total++; if (bus.err !== ErrEn) begin bad++; $display("FAIL err_multi got=%b exp=%b", bus.err, ErrEn); end
    repeat (3) @(negedge clk);
    total++; if (bus.err !== ErrEn) begin bad++; $display("FAIL err_sticky got=%b exp=%b", bus.err, ErrEn); end
    do_reset();
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", bus.err); end
    bus.credit_in = 1'b1;
    @(negedge clk);
    bus.credit_in = 1'b0;
    total++; if (bus.err !== ErrEn) begin bad++; $display("FAIL err_overflow got=%b exp=%b", bus.err, ErrEn); end
    do_reset();
    bus.arb_select = 5'b00001;
    @(negedge clk);
    idle_inputs();
    total++; if (bus.err !== ErrEn) begin bad++; $display("FAIL err_no_req got=%b exp=%b", bus.err, ErrEn); end
  endtask

  // Model: per-input packet streams, a lock owner, and a credit balance kept as plain integers.
  task automatic test_random();
    int                rem [N];
    logic [W-1:0]      cur [N];
    logic [N-1:0]      mv;
    logic              m_locked;
    int                m_owner;
    int                m_cred;
    logic              exp_ov;
    flit_t             exp_out;
    logic              cr;
    logic [N-1:0]      exp_req, grant, exp_rdy;
    int                s, g;
    logic              exp_next;
    do_reset();
    mv = '0; m_locked = 1'b0; m_owner = 0; m_cred = C; exp_ov = 1'b0; exp_out = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; cur[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      total++; if (bus.out_valid !== exp_ov) begin bad++; $display("FAIL rand_out_valid c=%0d got=%b exp=%b", cyc, bus.out_valid, exp_ov); end
      if (exp_ov) begin
        total++; if ({bus.out_tail, bus.out_flit} !== exp_out) begin bad++; $display("FAIL rand_out_flit c=%0d got=%b/%h exp=%b/%h", cyc, bus.out_tail, bus.out_flit, exp_out.tail, exp_out.payload); end
      end
      for (int i = 0; i < N; i++) begin
        if (!mv[i] && ($urandom_range(0, 2) != 0)) begin
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          cur[i] = $urandom;
          mv[i]  = 1'b1;
        end
        bus.in_flit[i*W +: W] = cur[i];
        bus.in_tail[i]        = mv[i] && (rem[i] == 1);
      end
      bus.in_valid   = mv;
      cr             = (m_cred < C) && ($urandom_range(0, 2) == 0);
      bus.credit_in  = cr;
      bus.arb_select = '0;
      #1;
      exp_req = (!m_locked && m_cred > 0) ? mv : '0;
      total++; if (bus.arb_requests !== exp_req) begin bad++; $display("FAIL rand_req c=%0d got=%b exp=%b", cyc, bus.arb_requests, exp_req); end
      grant = '0;
      if (exp_req != '0 && $urandom_range(0, 3) != 0) begin
        g = $urandom_range(0, N - 1);
        while (!exp_req[g]) g = (g + 1) % N;
        grant[g] = 1'b1;
      end
      bus.arb_select = grant;
      #1;
      exp_rdy = '0;
      if (!m_locked) exp_rdy = grant;
      else if (mv[m_owner] && m_cred > 0) exp_rdy[m_owner] = 1'b1;
      s = -1;
      for (int i = 0; i < N; i++) if (exp_rdy[i]) s = i;
      exp_next = (s >= 0) && (rem[s] == 1);
      total++; if (bus.in_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy); end
      total++; if (bus.arb_next !== exp_next) begin bad++; $display("FAIL rand_next c=%0d got=%b exp=%b", cyc, bus.arb_next, exp_next); end
      exp_ov = (s >= 0);
      if (s >= 0) begin
        exp_out.tail    = (rem[s] == 1);
        exp_out.payload = cur[s];
        m_locked        = (rem[s] != 1);
        m_owner         = s;
        rem[s]          = rem[s] - 1;
        mv[s]           = 1'b0;
        m_cred          = m_cred - 1;
      end
      if (cr) m_cred = m_cred + 1;
      @(negedge clk);
    end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rand_err got=%b exp=0", bus.err); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_flit();
    test_locked();
    test_credit_stall();
    test_same_cycle_credit();
    test_reset_mid_packet();
    test_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
